pe_job_issuer: RTL and testbench

Initiator side of the PE array data/result protocol. Accepts compute jobs from the chiplet controller into a small FIFO and tags each with a transaction ID. It drives one `pe_data_t` transfer at a time into the PE array interface, then waits for the matching `pe_result_t` and returns a completion, with error status, to the controller. It sits between the controller command path and the PE array interface, and enforces a single outstanding PE transaction.

---
 rtl/pe_job_issuer_pkg.sv | 21 ++
 rtl/pe_job_issuer_if.sv | 42 ++++
 rtl/pe_job_issuer.sv | 206 ++++++++++++++++++++
 tb/tb_pe_job_issuer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_job_issuer_pkg.sv
// Shared widths and transfer types for the PE array data/result protocol.
package pe_job_issuer_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned OP_WIDTH   = 2;
  localparam int unsigned TID_WIDTH  = 4;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [OP_WIDTH-1:0]   op_type;
    logic [TID_WIDTH-1:0]  trans_id;
  } pe_data_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result_data;
    logic [OP_WIDTH-1:0]   op_type;
    logic [TID_WIDTH-1:0]  trans_id;
  } pe_result_t;

endpackage

// File: rtl/pe_job_issuer_if.sv
// Job, PE request/result and completion signals of pe_job_issuer.
// master = the issuer itself, slave = controller plus PE array side.
interface pe_job_issuer_if;
  import pe_job_issuer_pkg::*;

  logic [DATA_WIDTH-1:0] job_a;
  logic [DATA_WIDTH-1:0] job_b;
  logic [OP_WIDTH-1:0]   job_op;
  logic                  job_valid;
  logic                  job_ready;

  pe_data_t              pe_data;
  logic                  pe_data_valid;
  logic                  pe_data_ready;

  pe_result_t            pe_result;
  logic                  pe_result_valid;
  logic                  pe_result_ready;

  logic [DATA_WIDTH-1:0] rsp_data;
  logic [TID_WIDTH-1:0]  rsp_tid;
  logic [1:0]            rsp_err;
  logic                  rsp_valid;
  logic                  rsp_ready;

  logic [7:0]            drop_count;

  modport master (
    input  job_a, job_b, job_op, job_valid, pe_data_ready,
           pe_result, pe_result_valid, rsp_ready,
    output job_ready, pe_data, pe_data_valid, pe_result_ready,
           rsp_data, rsp_tid, rsp_err, rsp_valid, drop_count
  );

  modport slave (
    output job_a, job_b, job_op, job_valid, pe_data_ready,
           pe_result, pe_result_valid, rsp_ready,
    input  job_ready, pe_data, pe_data_valid, pe_result_ready,
           rsp_data, rsp_tid, rsp_err, rsp_valid, drop_count
  );

endinterface

// File: rtl/pe_job_issuer.sv
// Queues controller jobs, issues one tagged PE request at a time and returns completions.
// Optional result timeout is compiled in with PE_JOB_ISSUER_TIMEOUT_EN.
module pe_job_issuer
  import pe_job_issuer_pkg::*;
#(
  parameter int unsigned JOB_FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic            clk,
  input logic            rst,
  pe_job_issuer_if.master bus
);

  localparam int unsigned PTR_W = $clog2(JOB_FIFO_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [OP_WIDTH-1:0]   op;
  } job_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESULT,
    RESPOND
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISMATCH = 2'b01,
    ERR_TIMEOUT  = 2'b10
  } err_t;

  state_t                state;
  state_t                state_next;

  job_t                  fifo_mem [JOB_FIFO_DEPTH];
  job_t                  fifo_head;
  logic [PTR_W:0]        wr_ptr;
  logic [PTR_W:0]        rd_ptr;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;

  logic [TID_WIDTH-1:0]  tid_ctr;
  pe_data_t              pe_data_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [TID_WIDTH-1:0]  rsp_tid_q;
  err_t                  rsp_err_q;
  logic [7:0]            drop_count_q;

  logic                  issue_xfer;
  logic                  result_xfer;
  logic                  result_match;
  logic                  drop;
  logic                  pe_data_valid_c;
  logic                  pe_result_ready_c;
  logic                  rsp_valid_c;

`ifdef PE_JOB_ISSUER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  tmo_hit;
`endif

  // Extra pointer MSB distinguishes full from empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push       = bus.job_valid && !fifo_full;
  assign fifo_head  = fifo_mem[rd_ptr[PTR_W-1:0]];

  assign result_match = (bus.pe_result.trans_id == pe_data_q.trans_id) &&
                        (bus.pe_result.op_type  == pe_data_q.op_type);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= '{a: bus.job_a, b: bus.job_b, op: bus.job_op};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next        = state;
    pop               = 1'b0;
    issue_xfer        = 1'b0;
    result_xfer       = 1'b0;
    drop              = 1'b0;
    pe_data_valid_c   = 1'b0;
    pe_result_ready_c = 1'b0;
    rsp_valid_c       = 1'b0;
`ifdef PE_JOB_ISSUER_TIMEOUT_EN
    tmo_hit           = 1'b0;
`endif
    case (state)
      IDLE: begin
        pe_result_ready_c = 1'b1;
        drop              = bus.pe_result_valid;
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        pe_data_valid_c = 1'b1;
        if (bus.pe_data_ready) begin
          issue_xfer = 1'b1;
          state_next = WAIT_RESULT;
        end
      end
      WAIT_RESULT: begin
        pe_result_ready_c = 1'b1;
        // A result on the final counted cycle beats the timeout.
        if (bus.pe_result_valid) begin
          result_xfer = 1'b1;
          state_next  = RESPOND;
        end
`ifdef PE_JOB_ISSUER_TIMEOUT_EN
        else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_hit    = 1'b1;
          state_next = RESPOND;
        end
`endif
      end
      RESPOND: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef PE_JOB_ISSUER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst || issue_xfer) begin
      tmo_cnt <= '0;
    end else if (state == WAIT_RESULT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      tid_ctr      <= '0;
      pe_data_q    <= '0;
      rsp_data_q   <= '0;
      rsp_tid_q    <= '0;
      rsp_err_q    <= ERR_OK;
      drop_count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        pe_data_q <= '{a:        fifo_head.a,
                       b:        fifo_head.b,
                       op_type:  fifo_head.op,
                       trans_id: tid_ctr};
      end
      if (issue_xfer) begin
        tid_ctr <= tid_ctr + 1'b1;
      end
      if (result_xfer) begin
        rsp_data_q <= bus.pe_result.result_data;
        rsp_tid_q  <= bus.pe_result.trans_id;
        rsp_err_q  <= result_match ? ERR_OK : ERR_MISMATCH;
      end
`ifdef PE_JOB_ISSUER_TIMEOUT_EN
      else if (tmo_hit) begin
        rsp_data_q <= '0;
        rsp_tid_q  <= pe_data_q.trans_id;
        rsp_err_q  <= ERR_TIMEOUT;
      end
`endif
      if (drop && (drop_count_q != '1)) begin
        drop_count_q <= drop_count_q + 1'b1;
      end
    end
  end

  assign bus.job_ready       = !fifo_full;
  assign bus.pe_data         = pe_data_q;
  assign bus.pe_data_valid   = pe_data_valid_c;
  assign bus.pe_result_ready = pe_result_ready_c;
  assign bus.rsp_data        = rsp_data_q;
  assign bus.rsp_tid         = rsp_tid_q;
  assign bus.rsp_err         = rsp_err_q;
  assign bus.rsp_valid       = rsp_valid_c;
  assign bus.drop_count      = drop_count_q;

endmodule

// File: tb/tb_pe_job_issuer.sv
// Directed bench for pe_job_issuer: issue/complete, FIFO full, mismatch, backpressure,
// reset mid-transaction, timeout (when PE_JOB_ISSUER_TIMEOUT_EN is defined) and drop saturation.
module tb_pe_job_issuer;
  import pe_job_issuer_pkg::*;

`ifdef PE_JOB_ISSUER_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`else
  localparam int unsigned TMO = 256;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  int                   vectors = 0;
  int                   miscompares = 0;
  logic [TID_WIDTH-1:0] exp_tid;
  logic [TID_WIDTH-1:0] last_tid;
  logic [7:0]           exp_drop;
  logic [DATA_WIDTH-1:0] held_data;

  pe_job_issuer_if bus ();

  pe_job_issuer #(
    .JOB_FIFO_DEPTH(4),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_job_ready"},  64'(bus.job_ready), 64'd1);
    check_eq({pfx, "_pe_data"},    64'(bus.pe_data), 64'd0);
    check_eq({pfx, "_pe_valid"},   64'(bus.pe_data_valid), 64'd0);
    check_eq({pfx, "_res_ready"},  64'(bus.pe_result_ready), 64'd1);
    check_eq({pfx, "_rsp_data"},   64'(bus.rsp_data), 64'd0);
    check_eq({pfx, "_rsp_tid"},    64'(bus.rsp_tid), 64'd0);
    check_eq({pfx, "_rsp_err"},    64'(bus.rsp_err), 64'd0);
    check_eq({pfx, "_rsp_valid"},  64'(bus.rsp_valid), 64'd0);
    check_eq({pfx, "_drop_count"}, 64'(bus.drop_count), 64'd0);
  endtask

  task automatic push_job(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b,
                          input logic [OP_WIDTH-1:0] op);
    int n = 0;
    bus.job_a     = a;
    bus.job_b     = b;
    bus.job_op    = op;
    bus.job_valid = 1'b1;
    while (!bus.job_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq("push_wait", 64'(bus.job_ready), 64'd1);
    tick();
    bus.job_valid = 1'b0;
  endtask

  // Waits for the request, checks its payload, accepts it for one cycle.
  task automatic issue_job(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b,
                           input logic [OP_WIDTH-1:0] op);
    pe_data_t pd;
    int n = 0;
    while (!bus.pe_data_valid && n < 50) begin
      tick();
      n++;
    end
    check_eq("pe_valid_wait", 64'(bus.pe_data_valid), 64'd1);
    pd = '{a: a, b: b, op_type: op, trans_id: exp_tid};
    check_eq($sformatf("pe_data_tid%0d", exp_tid), 64'(bus.pe_data), 64'(pd));
    bus.pe_data_ready = 1'b1;
    tick();
    bus.pe_data_ready = 1'b0;
    last_tid = exp_tid;
    exp_tid++;
    check_eq("wait_no_pe_valid", 64'(bus.pe_data_valid), 64'd0);
    check_eq("wait_res_ready", 64'(bus.pe_result_ready), 64'd1);
  endtask

  task automatic send_result(input logic [DATA_WIDTH-1:0] d, input logic [OP_WIDTH-1:0] op,
                             input logic [TID_WIDTH-1:0] tid);
    bus.pe_result       = '{result_data: d, op_type: op, trans_id: tid};
    bus.pe_result_valid = 1'b1;
    tick();
    bus.pe_result_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string pfx, input logic [DATA_WIDTH-1:0] d,
                            input logic [TID_WIDTH-1:0] tid, input logic [1:0] err);
    check_eq({pfx, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    check_eq({pfx, "_rsp_data"},  64'(bus.rsp_data), 64'(d));
    check_eq({pfx, "_rsp_tid"},   64'(bus.rsp_tid), 64'(tid));
    check_eq({pfx, "_rsp_err"},   64'(bus.rsp_err), 64'(err));
  endtask

  task automatic complete_rsp();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check_eq("rsp_done", 64'(bus.rsp_valid), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_tid  = '0;
    exp_drop = '0;
  endtask

  initial begin
    bus.job_a           = '0;
    bus.job_b           = '0;
    bus.job_op          = '0;
    bus.job_valid       = 1'b0;
    bus.pe_data_ready   = 1'b0;
    bus.pe_result       = '0;
    bus.pe_result_valid = 1'b0;
    bus.rsp_ready       = 1'b0;
    exp_tid             = '0;
    last_tid            = '0;
    exp_drop            = '0;

    tick();
    do_reset();
    check_reset_outputs("rst");

    // Basic job with push-to-request latency of two cycles
    push_job(16'd3, 16'd5, 2'd0);
    check_eq("lat_n1", 64'(bus.pe_data_valid), 64'd0);
    tick();
    check_eq("lat_n2", 64'(bus.pe_data_valid), 64'd1);
    issue_job(16'd3, 16'd5, 2'd0);
    send_result(16'(3 * 5), 2'd0, last_tid);
    expect_rsp("basic", 16'd15, 4'd0, 2'b00);
    complete_rsp();

    // Six jobs with the PE stalled; FIFO fills after five pushes
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.job_a     = 16'(i + 1);
      bus.job_b     = 16'(i + 2);
      bus.job_op    = 2'(i);
      bus.job_valid = 1'b1;
      check_eq($sformatf("fill_ready%0d", i), 64'(bus.job_ready), 64'd1);
      tick();
    end
    bus.job_valid = 1'b0;
    check_eq("fifo_full", 64'(bus.job_ready), 64'd0);
    tick();
    check_eq("fifo_full_hold", 64'(bus.job_ready), 64'd0);
    issue_job(16'd1, 16'd2, 2'd0);
    send_result(16'(1 * 2), 2'd0, last_tid);
    expect_rsp("q0", 16'd2, 4'd0, 2'b00);
    complete_rsp();
    push_job(16'd6, 16'd7, 2'd1);
    for (int i = 1; i < 6; i++) begin
      issue_job(16'(i + 1), 16'(i + 2), 2'(i));
      send_result(16'((i + 1) * (i + 2)), 2'(i), last_tid);
      expect_rsp($sformatf("q%0d", i), 16'((i + 1) * (i + 2)), 4'(i), 2'b00);
      complete_rsp();
    end

    // Returned ID one ahead of the issued ID
    push_job(16'd7, 16'd9, 2'd2);
    issue_job(16'd7, 16'd9, 2'd2);
    send_result(16'h003F, 2'd2, last_tid + 1'b1);
    expect_rsp("tid_mm", 16'h003F, 4'd7, 2'b01);
    complete_rsp();

    // Matching ID but wrong op
    push_job(16'd4, 16'd4, 2'd3);
    issue_job(16'd4, 16'd4, 2'd3);
    send_result(16'h0010, 2'd1, last_tid);
    expect_rsp("op_mm", 16'h0010, 4'd7, 2'b01);
    complete_rsp();

    // Completion backpressure with a second job queued
    push_job(16'd10, 16'd11, 2'd1);
    push_job(16'd12, 16'd13, 2'd2);
    issue_job(16'd10, 16'd11, 2'd1);
    held_data = 16'd110;
    send_result(held_data, 2'd1, last_tid);
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("hold%0d_valid", i), 64'(bus.rsp_valid), 64'd1);
      check_eq($sformatf("hold%0d_data", i), 64'(bus.rsp_data), 64'(held_data));
      check_eq($sformatf("hold%0d_no_issue", i), 64'(bus.pe_data_valid), 64'd0);
      tick();
    end
    expect_rsp("hold", 16'd110, 4'd8, 2'b00);
    complete_rsp();
    issue_job(16'd12, 16'd13, 2'd2);
    send_result(16'd156, 2'd2, last_tid);
    expect_rsp("hold_next", 16'd156, 4'd9, 2'b00);
    complete_rsp();

    // Reset while waiting for a result; the late result is a drop
    push_job(16'd2, 16'd2, 2'd0);
    issue_job(16'd2, 16'd2, 2'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_tid  = '0;
    exp_drop = '0;
    check_reset_outputs("midrst");
    send_result(16'd4, 2'd0, 4'd10);
    exp_drop++;
    check_eq("stale_drop", 64'(bus.drop_count), 64'(exp_drop));
    push_job(16'd8, 16'd3, 2'd1);
    issue_job(16'd8, 16'd3, 2'd1);
    send_result(16'd24, 2'd1, last_tid);
    expect_rsp("after_rst", 16'd24, 4'd0, 2'b00);
    complete_rsp();

`ifdef PE_JOB_ISSUER_TIMEOUT_EN
    // Silent responder: timeout exactly TMO edges after the request transfer
    push_job(16'd5, 16'd5, 2'd3);
    issue_job(16'd5, 16'd5, 2'd3);
    for (int k = 1; k < 16; k++) begin
      tick();
      check_eq($sformatf("tmo_wait%0d", k), 64'(bus.rsp_valid), 64'd0);
    end
    tick();
    expect_rsp("tmo", 16'd0, 4'd1, 2'b10);
    complete_rsp();
    send_result(16'd25, 2'd3, 4'd1);
    exp_drop++;
    check_eq("late_drop", 64'(bus.drop_count), 64'(exp_drop));

    // Result on the last counted cycle wins over the timeout
    push_job(16'd9, 16'd9, 2'd0);
    issue_job(16'd9, 16'd9, 2'd0);
    for (int k = 1; k < 16; k++) begin
      tick();
    end
    send_result(16'd81, 2'd0, last_tid);
    expect_rsp("tmo_race", 16'd81, 4'd2, 2'b00);
    complete_rsp();
`else
    // Without the timeout the wait outlasts the default limit
    push_job(16'd5, 16'd5, 2'd3);
    issue_job(16'd5, 16'd5, 2'd3);
    for (int k = 0; k < 300; k++) begin
      tick();
    end
    check_eq("no_tmo_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("no_tmo_ready", 64'(bus.pe_result_ready), 64'd1);
    send_result(16'd25, 2'd3, last_tid);
    expect_rsp("no_tmo", 16'd25, 4'd1, 2'b00);
    complete_rsp();
`endif

    // drop_count saturates at 255
    bus.pe_result       = '0;
    bus.pe_result_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      tick();
    end
    bus.pe_result_valid = 1'b0;
    check_eq("drop_sat", 64'(bus.drop_count), 64'd255);
    tick();
    check_eq("drop_sat_hold", 64'(bus.drop_count), 64'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
